// File: rtl/xfer_pkg.sv
// Shared types and helpers for the service-gate transfer sequencer.
package xfer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    CLEAR = 2'd3
  } state_t;

  localparam logic [2:0] GATE_NONE = 3'd7;
  localparam int         NGATES    = 7;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  // Active-low one-hot gate decode; GATE_NONE leaves every gate released.
  function automatic logic [NGATES-1:0] gate_dec_n(input logic [2:0] g);
    logic [NGATES-1:0] r;
    r = '1;
    if (g != GATE_NONE) r[g] = 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/xfer_arb2.sv
// Two-way A/B arbiter: B is preferred but may take at most B_RUN_MAX
// consecutive grants while A is waiting.
module xfer_arb2 #(
  parameter int B_RUN_MAX = 3
) (
  input  logic CLOCK,
  input  logic SIM_RST,
  input  logic A_VALID,
  input  logic B_VALID,
  input  logic INHIBIT,
  input  logic idle,
  output logic grant_a,
  output logic grant_b
);

  localparam int             BW   = $clog2(B_RUN_MAX + 1);
  localparam logic [BW-1:0]  BMAX = BW'(B_RUN_MAX);

  logic [BW-1:0] brun;
  logic          en;

  always_comb begin
    en      = idle && !INHIBIT;
    grant_b = en && B_VALID && (!A_VALID || (brun < BMAX));
    grant_a = en && A_VALID && !grant_b;
  end

  always_ff @(posedge CLOCK or posedge SIM_RST) begin
    if (SIM_RST) begin
      brun <= '0;
    end else if (grant_a) begin
      brun <= '0;
    end else if (grant_b) begin
      if (!A_VALID)          brun <= '0;
      else if (brun != BMAX) brun <= brun + 1'b1;
    end
  end

endmodule

// File: rtl/xfer_gate_sequencer.sv
// Register-transfer microstep sequencer: grants A or B, then drives
// READ -> WRITE -> CLEAR phase strobes and one-hot gate enables.
module xfer_gate_sequencer
  import xfer_pkg::*;
#(
  parameter int RT_CYC    = 2,
  parameter int WT_CYC    = 2,
  parameter int CT_CYC    = 1,
  parameter int B_RUN_MAX = 3
) (
  input  logic              CLOCK,
  input  logic              SIM_RST,
  input  logic              INHIBIT,
  input  logic              A_VALID,
  input  logic [2:0]        A_SRC,
  input  logic [2:0]        A_DST,
  input  logic              A_CLR,
  output logic              A_READY,
  output logic              A_DONE,
  input  logic              B_VALID,
  input  logic [2:0]        B_SRC,
  input  logic [2:0]        B_DST,
  input  logic              B_CLR,
  output logic              B_READY,
  output logic              B_DONE,
  output logic              RT_n,
  output logic              WT_n,
  output logic              CT_n,
  output logic [NGATES-1:0] RD_n,
  output logic [NGATES-1:0] WR_n,
  output logic [NGATES-1:0] CL_n,
  output logic              BUSY
);

  localparam int            CW      = $clog2(max3(RT_CYC, WT_CYC, CT_CYC) + 1);
  localparam logic [CW-1:0] RT_LAST = CW'(RT_CYC - 1);
  localparam logic [CW-1:0] WT_LAST = CW'(WT_CYC - 1);
  localparam logic [CW-1:0] CT_LAST = CW'(CT_CYC - 1);

  state_t        state, nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    src_q, dst_q, src_n, dst_n;
  logic          clr_q, clr_n, own_b_q, own_b_n;
  logic          grant_a, grant_b, arb_idle, last_clear;

  // READY must stay low while reset is held, even though it is combinational.
  assign arb_idle = (state == IDLE) && !SIM_RST;

  xfer_arb2 #(
    .B_RUN_MAX(B_RUN_MAX)
  ) u_arb (
    .CLOCK  (CLOCK),
    .SIM_RST(SIM_RST),
    .A_VALID(A_VALID),
    .B_VALID(B_VALID),
    .INHIBIT(INHIBIT),
    .idle   (arb_idle),
    .grant_a(grant_a),
    .grant_b(grant_b)
  );

  assign A_READY = grant_a;
  assign B_READY = grant_b;

  // Payload is only ever replaced on a grant, which only happens in IDLE.
  always_comb begin
    src_n   = src_q;
    dst_n   = dst_q;
    clr_n   = clr_q;
    own_b_n = own_b_q;
    if (grant_b) begin
      src_n   = B_SRC;
      dst_n   = B_DST;
      clr_n   = B_CLR;
      own_b_n = 1'b1;
    end else if (grant_a) begin
      src_n   = A_SRC;
      dst_n   = A_DST;
      clr_n   = A_CLR;
      own_b_n = 1'b0;
    end
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = cnt + 1'b1;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (grant_a || grant_b) nxt = READ;
      end
      READ: begin
        if (cnt == RT_LAST) begin
          nxt     = WRITE;
          cnt_nxt = '0;
        end
      end
      WRITE: begin
        if (cnt == WT_LAST) begin
          nxt     = CLEAR;
          cnt_nxt = '0;
        end
      end
      CLEAR: begin
        if (cnt == CT_LAST) begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  assign last_clear = (nxt == CLEAR) && (cnt_nxt == CT_LAST);

  // Outputs are registered from the next-state decode so each strobe lines
  // up with the state it belongs to without any combinational path.
  always_ff @(posedge CLOCK or posedge SIM_RST) begin
    if (SIM_RST) begin
      state   <= IDLE;
      cnt     <= '0;
      src_q   <= GATE_NONE;
      dst_q   <= GATE_NONE;
      clr_q   <= 1'b0;
      own_b_q <= 1'b0;
      RT_n    <= 1'b1;
      WT_n    <= 1'b1;
      CT_n    <= 1'b1;
      RD_n    <= '1;
      WR_n    <= '1;
      CL_n    <= '1;
      A_DONE  <= 1'b0;
      B_DONE  <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      state   <= nxt;
      cnt     <= cnt_nxt;
      src_q   <= src_n;
      dst_q   <= dst_n;
      clr_q   <= clr_n;
      own_b_q <= own_b_n;
      RT_n    <= (nxt != READ);
      WT_n    <= (nxt != WRITE);
      CT_n    <= (nxt != CLEAR);
      RD_n    <= ((nxt == READ) || (nxt == WRITE)) ? gate_dec_n(src_n) : '1;
      WR_n    <= (nxt == WRITE) ? gate_dec_n(dst_n) : '1;
      CL_n    <= ((nxt == CLEAR) && clr_n) ? gate_dec_n(dst_n) : '1;
      A_DONE  <= last_clear && !own_b_n;
      B_DONE  <= last_clear && own_b_n;
      BUSY    <= (nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_xfer_gate_sequencer.sv
// Self-checking bench for xfer_gate_sequencer: transaction-level model plus
// directed literal checks and a randomized run.
module tb_xfer_gate_sequencer;

  localparam int RT   = 2;
  localparam int WT   = 2;
  localparam int CT   = 1;
  localparam int BMAX = 3;
  localparam int L    = RT + WT + CT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inh = 1'b0;
  logic       av = 1'b0, ac = 1'b0, bv = 1'b0, bc = 1'b0;
  logic [2:0] a_src = 3'd0, a_dst = 3'd0, b_src = 3'd0, b_dst = 3'd0;

  logic       A_READY, A_DONE, B_READY, B_DONE;
  logic       RT_n, WT_n, CT_n, BUSY;
  logic [6:0] RD_n, WR_n, CL_n;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Model: a transfer is just "granted at cycle m_start"; offset decides phase.
  int m_start = -1;
  int m_owner = 0, m_src = 7, m_dst = 7, m_clr = 0, m_brun = 0;
  int ready_log[$];
  int exp_seq[8] = '{1, 1, 1, 0, 1, 1, 1, 0};

  xfer_gate_sequencer #(
    .RT_CYC(RT),
    .WT_CYC(WT),
    .CT_CYC(CT),
    .B_RUN_MAX(BMAX)
  ) dut (
    .CLOCK  (clk),
    .SIM_RST(rst),
    .INHIBIT(inh),
    .A_VALID(av),
    .A_SRC  (a_src),
    .A_DST  (a_dst),
    .A_CLR  (ac),
    .A_READY(A_READY),
    .A_DONE (A_DONE),
    .B_VALID(bv),
    .B_SRC  (b_src),
    .B_DST  (b_dst),
    .B_CLR  (bc),
    .B_READY(B_READY),
    .B_DONE (B_DONE),
    .RT_n   (RT_n),
    .WT_n   (WT_n),
    .CT_n   (CT_n),
    .RD_n   (RD_n),
    .WR_n   (WR_n),
    .CL_n   (CL_n),
    .BUSY   (BUSY)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog cyc=%0d got=running required=finished", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%b required=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chk7(input string nm, input logic [6:0] act, input logic [6:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%b required=%b", nm, cyc, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s cyc=%0d got=%0d required=%0d", nm, cyc, act, exp);
    end
  endtask

  function automatic logic [6:0] gate_n(input int g);
    logic [6:0] r;
    r = 7'h7F;
    if (g != 7) r = 7'h7F ^ (7'd1 << g);
    return r;
  endfunction

  // One clock cycle: drive after the edge, check at the falling edge, advance model.
  task automatic step(input logic r, input logic i,
                      input logic a_v, input logic [2:0] a_s, input logic [2:0] a_d, input logic a_c,
                      input logic b_v, input logic [2:0] b_s, input logic [2:0] b_d, input logic b_c);
    int k;
    bit act, ga, gb;
    @(posedge clk);
    #1;
    rst = r; inh = i;
    av = a_v; a_src = a_s; a_dst = a_d; ac = a_c;
    bv = b_v; b_src = b_s; b_dst = b_d; bc = b_c;
    @(negedge clk);
    k   = (m_start >= 0) ? cyc - m_start : 0;
    act = !r && (k >= 1) && (k <= L);
    gb  = !r && !act && !i && b_v && (!a_v || (m_brun < BMAX));
    ga  = !r && !act && !i && a_v && !gb;

    chk1("A_READY", A_READY, ga);
    chk1("B_READY", B_READY, gb);
    chk1("RT_n", RT_n, !(act && k <= RT));
    chk1("WT_n", WT_n, !(act && k > RT && k <= RT + WT));
    chk1("CT_n", CT_n, !(act && k > RT + WT));
    chk7("RD_n", RD_n, (act && k <= RT + WT) ? gate_n(m_src) : 7'h7F);
    chk7("WR_n", WR_n, (act && k > RT && k <= RT + WT) ? gate_n(m_dst) : 7'h7F);
    chk7("CL_n", CL_n, (act && k > RT + WT && m_clr != 0) ? gate_n(m_dst) : 7'h7F);
    chk1("A_DONE", A_DONE, act && k == L && m_owner == 0);
    chk1("B_DONE", B_DONE, act && k == L && m_owner == 1);
    chk1("BUSY", BUSY, act);
    chk1("inv_rd_onehot", $countones(~RD_n) <= 1, 1'b1);
    chk1("inv_wr_onehot", $countones(~WR_n) <= 1, 1'b1);
    chk1("inv_cl_onehot", $countones(~CL_n) <= 1, 1'b1);
    chk1("inv_one_ready", A_READY && B_READY, 1'b0);
    chk1("inv_wr_in_wt", (WR_n != 7'h7F) && WT_n, 1'b0);

    if (A_READY) ready_log.push_back(0);
    if (B_READY) ready_log.push_back(1);

    if (r) begin
      m_start = -1;
      m_brun  = 0;
    end else if (ga || gb) begin
      m_start = cyc;
      m_owner = gb ? 1 : 0;
      m_src   = gb ? int'(b_s) : int'(a_s);
      m_dst   = gb ? int'(b_d) : int'(a_d);
      m_clr   = gb ? int'(b_c) : int'(a_c);
      if (ga)       m_brun = 0;
      else if (a_v) m_brun = (m_brun < BMAX) ? m_brun + 1 : BMAX;
      else          m_brun = 0;
    end
    cyc++;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++)
      step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b1, 3'd1, 3'd1, 1'b0, 1'b1, 3'd2, 3'd2, 1'b0);
    chk7("rst_rd", RD_n, 7'h7F);
    chk1("rst_rt", RT_n, 1'b1);
    chk1("rst_ready", A_READY | B_READY, 1'b0);
    idle_steps(1);

    // Basic A transfer with literal timeline
    step(1'b0, 1'b0, 1'b1, 3'd0, 3'd3, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    chk1("t1_ready", A_READY, 1'b1);
    for (int c = 1; c <= 6; c++) begin
      idle_steps(1);
      if (c <= 4) chk7("t1_rd", RD_n, 7'b1111110);
      if (c == 3 || c == 4) chk7("t1_wr", WR_n, 7'b1110111);
      if (c == 5) begin
        chk7("t1_cl", CL_n, 7'b1110111);
        chk1("t1_done", A_DONE, 1'b1);
      end
      if (c == 6) chk1("t1_idle", BUSY, 1'b0);
    end

    // Starvation bound: both requesters held
    ready_log.delete();
    for (int c = 0; c < 80 && ready_log.size() < 8; c++)
      step(1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 1'b0, 1'b1, 3'd4, 3'd5, 1'b1);
    chki("t2_grants", ready_log.size(), 8);
    for (int i = 0; i < 8 && i < ready_log.size(); i++)
      chki("t2_order", ready_log[i], exp_seq[i]);
    idle_steps(L + 1);

    // No-gate transfer still strobes
    step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0, 1'b1, 3'd7, 3'd7, 1'b1);
    chk1("t3_ready", B_READY, 1'b1);
    for (int c = 1; c <= L; c++) begin
      idle_steps(1);
      chk7("t3_rd", RD_n & WR_n & CL_n, 7'h7F);
      if (c == 1) chk1("t3_rt", RT_n, 1'b0);
      if (c == 3) chk1("t3_wt", WT_n, 1'b0);
      if (c == 5) begin
        chk1("t3_ct", CT_n, 1'b0);
        chk1("t3_done", B_DONE, 1'b1);
      end
    end
    idle_steps(1);

    // INHIBIT before grant and mid-transfer
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
      chk1("t4_inh_ready", A_READY, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 3'd1, 3'd2, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0);
    chk1("t4_grant", A_READY, 1'b1);
    idle_steps(2);
    for (int c = 3; c <= 9; c++) begin
      step(1'b0, 1'b1, 1'b1, 3'd5, 3'd6, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
      if (c == 5) chk1("t4_done", A_DONE, 1'b1);
      if (c >= 6) chk1("t4_hold", A_READY, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 3'd5, 3'd6, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    chk1("t4_release", A_READY, 1'b1);
    idle_steps(L + 1);

    // Async reset mid-WRITE
    step(1'b0, 1'b0, 1'b1, 3'd2, 3'd4, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    for (int c = 1; c <= 2; c++)
      step(1'b0, 1'b0, 1'b1, 3'd2, 3'd4, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3'd2, 3'd4, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    chk7("t5_wr", WR_n, 7'h7F);
    chk1("t5_wt", WT_n, 1'b1);
    chk1("t5_busy", BUSY, 1'b0);
    step(1'b1, 1'b0, 1'b1, 3'd2, 3'd4, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 3'd2, 3'd4, 1'b1, 1'b0, 3'd0, 3'd0, 1'b0);
    chk1("t5_regrant", A_READY, 1'b1);
    chk1("t5_no_done", A_DONE, 1'b0);
    idle_steps(L + 1);

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 299) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)),
           $urandom_range(0, 2) != 0, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
